// File: rtl/bg_arb_pkg.sv
// Shared types for the background tile RAM arbiter: FSM states, byte-lane
// encoding and the read-lane selection helper.
package bg_arb_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int HOLD_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VID_A = 3'd1,
    ST_VID_D = 3'd2,
    ST_CPU_A = 3'd3,
    ST_CPU_D = 3'd4
  } arb_state_t;

  // Bit 0 = lo lane selected, bit 1 = hi lane selected.
  typedef enum logic [1:0] {
    LANE_NONE = 2'b00,
    LANE_LO   = 2'b01,
    LANE_HI   = 2'b10,
    LANE_BOTH = 2'b11
  } lane_t;

  function automatic logic [7:0] lane_byte(input lane_t lanes, input logic [15:0] q);
    return (lanes == LANE_HI) ? q[15:8] : q[7:0];
  endfunction

endpackage

// File: rtl/bg_tileram_arbiter_if.sv
// Z80 side of the tile RAM arbiter: lane selects, strobe, address/data and WAIT.
interface bg_tileram_arbiter_if #(
  parameter int ADDR_W = 11
) ();

  logic              cpu_cs_lo_n;
  logic              cpu_cs_hi_n;
  logic              cpu_wr_n;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic [7:0]        cpu_dout;
  logic              cpu_wait_n;

  modport master (
    output cpu_cs_lo_n, cpu_cs_hi_n, cpu_wr_n, cpu_addr, cpu_din,
    input  cpu_dout, cpu_wait_n
  );

  modport slave (
    input  cpu_cs_lo_n, cpu_cs_hi_n, cpu_wr_n, cpu_addr, cpu_din,
    output cpu_dout, cpu_wait_n
  );

endinterface

// File: rtl/bg_arb_hold_timer.sv
// Loadable 4-bit down counter that stretches Z80 WAIT after data capture.
module bg_arb_hold_timer
  import bg_arb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [HOLD_W-1:0] i_load_val,
  output logic              o_zero
);

  logic [HOLD_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bg_tileram_arbiter.sv
// Shares the single-port background tile RAM between the video tile fetcher
// (strict priority) and the Z80, which is stalled through an active-low WAIT.
module bg_tileram_arbiter
  import bg_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int HOLD_CYC = 2
) (
  input  logic                 master_clk,
  input  logic                 reset,
  input  logic                 fetch_req,
  input  logic [ADDR_W-1:0]    fetch_addr,
  output logic [15:0]          tile_q,
  output logic                 tile_valid,
  bg_tileram_arbiter_if.slave  cpu,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [7:0]           ram_din,
  output logic                 ram_we_lo,
  output logic                 ram_we_hi,
  input  logic [15:0]          ram_q,
  output logic                 overrun
);

  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYC);

  arb_state_t r_state, w_state_nxt;

  logic              r_cs_prev;
  logic              r_cpu_pend;
  logic              r_cpu_done;
  logic              r_cpu_wr;
  lane_t             r_cpu_lanes;
  logic [ADDR_W-1:0] r_cpu_addr;
  logic [7:0]        r_cpu_din;
  logic [7:0]        r_cpu_dout;
  logic              r_vid_pend;
  logic [ADDR_W-1:0] r_vid_addr;
  logic [15:0]       r_tile_q;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_din;
  logic              r_we_lo;
  logic              r_we_hi;
  logic              r_overrun;

  logic w_cs_any;
  logic w_cs_fall;
  logic w_arb_pt;
  logic w_cpu_keep;
  logic w_hold_zero;
  logic w_sel_lo;
  logic w_sel_hi;

  assign w_cs_any  = !cpu.cpu_cs_lo_n | !cpu.cpu_cs_hi_n;
  assign w_cs_fall = w_cs_any & !r_cs_prev;
  assign w_sel_lo  = (r_cpu_lanes == LANE_LO) || (r_cpu_lanes == LANE_BOTH);
  assign w_sel_hi  = (r_cpu_lanes == LANE_HI) || (r_cpu_lanes == LANE_BOTH);

  // CPU_D only delivers data if the select is still the one that started it.
  assign w_cpu_keep = (r_state == ST_CPU_D) & w_cs_any & !w_cs_fall;

  // Data-phase states double as arbitration points so a queued requester
  // starts its address phase without an extra IDLE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_arb_pt    = 1'b0;
    case (r_state)
      ST_VID_A: w_state_nxt = ST_VID_D;
      ST_CPU_A: w_state_nxt = ST_CPU_D;
      default: begin
        w_arb_pt = 1'b1;
        if (fetch_req | r_vid_pend)        w_state_nxt = ST_VID_A;
        else if (r_cpu_pend & w_cs_any)    w_state_nxt = ST_CPU_A;
        else                               w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge master_clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cs_prev  <= 1'b0;
      r_cpu_pend <= 1'b0;
      r_cpu_done <= 1'b0;
      r_cpu_dout <= '0;
      r_vid_pend <= 1'b0;
      r_tile_q   <= '0;
      r_ram_addr <= '0;
      r_we_lo    <= 1'b0;
      r_we_hi    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cs_prev <= w_cs_any;
      r_we_lo   <= 1'b0;
      r_we_hi   <= 1'b0;

      if (fetch_req & r_vid_pend) r_overrun <= 1'b1;

      if (w_arb_pt && w_state_nxt == ST_VID_A) begin
        r_vid_pend <= 1'b0;
        r_ram_addr <= fetch_req ? fetch_addr : r_vid_addr;
      end else if (fetch_req) begin
        r_vid_pend <= 1'b1;
      end

      if (r_state == ST_VID_D) r_tile_q <= ram_q;

      if (w_state_nxt == ST_CPU_A) begin
        r_cpu_pend <= 1'b0;
        r_ram_addr <= r_cpu_addr;
        r_we_lo    <= r_cpu_wr & w_sel_lo;
        r_we_hi    <= r_cpu_wr & w_sel_hi;
      end else if (!w_cs_any) begin
        r_cpu_pend <= 1'b0;
      end

      if (w_cs_fall) begin
        r_cpu_pend <= 1'b1;
        r_cpu_done <= 1'b0;
      end else if (w_cpu_keep) begin
        r_cpu_done <= 1'b1;
        r_cpu_dout <= lane_byte(r_cpu_lanes, ram_q);
      end
    end
  end

  always_ff @(posedge master_clk) begin
    if (fetch_req) r_vid_addr <= fetch_addr;
    if (w_cs_fall) begin
      r_cpu_addr  <= cpu.cpu_addr;
      r_cpu_din   <= cpu.cpu_din;
      r_cpu_wr    <= !cpu.cpu_wr_n;
      r_cpu_lanes <= lane_t'({!cpu.cpu_cs_hi_n, !cpu.cpu_cs_lo_n});
    end
    if (w_state_nxt == ST_CPU_A) r_ram_din <= r_cpu_din;
  end

  bg_arb_hold_timer u_hold (
    .i_clk      (master_clk),
    .i_rst      (reset),
    .i_load     (w_cpu_keep),
    .i_load_val (HOLD_LD),
    .o_zero     (w_hold_zero)
  );

  // A fresh select edge must pull WAIT low even though the previous access
  // still reads as done for this one cycle.
  assign cpu.cpu_wait_n = !(w_cs_any & !(r_cpu_done & !w_cs_fall & w_hold_zero));
  assign cpu.cpu_dout   = r_cpu_dout;

  assign tile_valid = (r_state == ST_VID_D);
  assign tile_q     = (r_state == ST_VID_D) ? ram_q : r_tile_q;
  assign ram_addr   = r_ram_addr;
  assign ram_din    = r_ram_din;
  assign ram_we_lo  = r_we_lo;
  assign ram_we_hi  = r_we_hi;
  assign overrun    = r_overrun;

endmodule
